// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the core's memory-port arbiter.
//   arb_state_t   : arbiter FSM states
//   arb_src_t     : requester identity (instruction fetch or data port)
//   ARB_ERR_RDATA : read data returned with a timeout error response
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_t;

  localparam logic [31:0] ARB_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick between the instruction and data
// requesters. On a tie, the source that was not granted last wins.
//   instr_req_i / data_req_i : pending requests
//   last_src_i               : source granted most recently
//   instr_win_o / data_win_o : one-hot winner (both 0 when nothing pending)
// -----------------------------------------------------------------------------
module rr_arb2
  import cpu_pkg::*;
(
  input  logic     instr_req_i,
  input  logic     data_req_i,
  input  arb_src_t last_src_i,
  output logic     instr_win_o,
  output logic     data_win_o
);

  // Winner selection
  always_comb begin
    instr_win_o = 1'b0;
    data_win_o  = 1'b0;
    if (instr_req_i && data_req_i) begin
      if (last_src_i == SRC_INSTR) begin
        data_win_o = 1'b1;
      end else begin
        instr_win_o = 1'b1;
      end
    end else if (instr_req_i) begin
      instr_win_o = 1'b1;
    end else if (data_req_i) begin
      data_win_o = 1'b1;
    end else begin
      instr_win_o = 1'b0;
      data_win_o  = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single-ported memory between the instruction-fetch and data ports.
// One transaction outstanding at a time; round-robin between the requesters;
// the response is routed back to the originator; a cycle counter turns a stuck
// memory into an error response.
//   instr_* : fetch port (req/addr in, gnt/rvalid/err/rdata out)
//   data_*  : data port  (req/we/addr/wdata in, gnt/rvalid/err/rdata out)
//   mem_*   : memory side req/gnt/rvalid handshake
// Only *_gnt_o is combinational; every other output comes from a flop.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              instr_req_i,
  input  logic [DATA_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic              instr_err_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [DATA_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic              data_err_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;

  arb_state_t        state_q, state_d;
  arb_src_t          last_src_q, last_src_d;
  arb_src_t          src_q, src_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              instr_rvalid_q, instr_rvalid_d;
  logic              instr_err_q, instr_err_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic              data_rvalid_q, data_rvalid_d;
  logic              data_err_q, data_err_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic              instr_win_s, data_win_s;
  logic              instr_gnt_s, data_gnt_s;
  logic              timeout_s;
  logic              rsp_valid_s, rsp_err_s;
  logic [DATA_W-1:0] rsp_rdata_s;

  rr_arb2 u_rr_arb2 (
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .last_src_i  (last_src_q),
    .instr_win_o (instr_win_s),
    .data_win_o  (data_win_s)
  );

  // The counter holds the number of cycles already spent in the current
  // wait phase, so this cycle is the TIMEOUT-th one when cnt+1 hits TIMEOUT.
  assign timeout_s = (TIMEOUT != 32'd0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

  // Next-state, request capture, timeout counter and response routing
  always_comb begin
    state_d     = state_q;
    last_src_d  = last_src_q;
    src_d       = src_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    instr_gnt_s = 1'b0;
    data_gnt_s  = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_rdata_s = '0;

    case (state_q)
      IDLE: begin
        if (instr_win_s || data_win_s) begin
          instr_gnt_s = instr_win_s;
          data_gnt_s  = data_win_s;
          src_d       = data_win_s ? SRC_DATA : SRC_INSTR;
          last_src_d  = data_win_s ? SRC_DATA : SRC_INSTR;
          addr_d      = data_win_s ? data_addr_i : instr_addr_i;
          we_d        = data_win_s & data_we_i;
          wdata_d     = data_win_s ? data_wdata_i : '0;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A grant wins over a timeout landing in the same cycle; an rvalid
        // seen here is ignored because the memory has not accepted yet.
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end else if (timeout_s) begin
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_rdata_s = DATA_W'(ARB_ERR_RDATA);
          state_d     = RESP;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          rsp_valid_s = 1'b1;
          rsp_rdata_s = we_q ? '0 : mem_rdata_i;
          state_d     = RESP;
        end else if (timeout_s) begin
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_rdata_s = DATA_W'(ARB_ERR_RDATA);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response outputs are only non-zero in the single RESP cycle.
    instr_rvalid_d = rsp_valid_s && (src_q == SRC_INSTR);
    instr_err_d    = rsp_err_s && (src_q == SRC_INSTR);
    instr_rdata_d  = (rsp_valid_s && (src_q == SRC_INSTR)) ? rsp_rdata_s : '0;
    data_rvalid_d  = rsp_valid_s && (src_q == SRC_DATA);
    data_err_d     = rsp_err_s && (src_q == SRC_DATA);
    data_rdata_d   = (rsp_valid_s && (src_q == SRC_DATA)) ? rsp_rdata_s : '0;
  end

  // State, request and response registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= IDLE;
      last_src_q     <= SRC_INSTR;
      src_q          <= SRC_INSTR;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      instr_rdata_q  <= '0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_src_q     <= last_src_d;
      src_q          <= src_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      instr_rvalid_q <= instr_rvalid_d;
      instr_err_q    <= instr_err_d;
      instr_rdata_q  <= instr_rdata_d;
      data_rvalid_q  <= data_rvalid_d;
      data_err_q     <= data_err_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  // Grants are held low while reset is asserted even if requests are high.
  assign instr_gnt_o    = instr_gnt_s & reset_ni;
  assign data_gnt_o     = data_gnt_s & reset_ni;
  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_err_o    = instr_err_q;
  assign instr_rdata_o  = instr_rdata_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_err_o     = data_err_q;
  assign data_rdata_o   = data_rdata_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the core's instruction-fetch port and data port. It arbitrates round-robin between the two requesters and keeps at most one transaction outstanding. Each accepted request is forwarded over a req/gnt/rvalid memory handshake, and the response is routed back to its originator. A timeout guards against a stuck memory. It sits between `micro_riscv` (and its multicycle successors) and the memory model/bus.

## Interface
Parameters:
- `DATA_W`, 32, data and address width
- `TIMEOUT`, 255, maximum cycles spent waiting for `mem_gnt_i` or `mem_rvalid_i`; 0 disables the timeout

Ports:
- `clk_i`  in  1  clock, rising edge
- `reset_ni`  in  1  reset, asynchronous, active-low
- `instr_req_i`  in  1  instruction read request; held until granted
- `instr_addr_i`  in  DATA_W  fetch address
- `instr_gnt_o`  out  1  instruction request accepted
- `instr_rvalid_o`  out  1  instruction response valid
- `instr_err_o`  out  1  response is a timeout error
- `instr_rdata_o`  out  DATA_W  fetched word
- `data_req_i`  in  1  data request; held until granted
- `data_we_i`  in  1  1 = write, 0 = read
- `data_addr_i`, `data_wdata_i`  in  DATA_W  address and write data
- `data_gnt_o`, `data_rvalid_o`, `data_err_o`  out  1  same meaning as the instruction side
- `data_rdata_o`  out  DATA_W  read data; 0 for writes
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`, `mem_wdata_o`  out  DATA_W  memory address and write data
- `mem_gnt_i`  in  1  memory accepted the request
- `mem_rvalid_i`  in  1  memory response valid; one per grant
- `mem_rdata_i`  in  DATA_W  memory read data

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT_RSP`, `RESP`.
- IDLE:
  - If any request is pending, select a winner and pulse the winner's `*_gnt_o` combinationally in that cycle.
  - Capture addr, we and wdata into the request register (instruction side captures we=0, wdata=0), record the source, go to REQ.
- Arbitration: round-robin on `last_src`.
  - With both requesting, the source not granted last wins.
  - With one requesting, that source wins.
  - `last_src` updates on every grant; its reset value is INSTR, so the first tie goes to DATA.
- REQ: `mem_req_o`=1 with the registered addr/we/wdata, all held stable. On `mem_gnt_i`, go to WAIT_RSP.
- WAIT_RSP: on `mem_rvalid_i`, register `mem_rdata_i` (forced to 0 for writes), set err=0, go to RESP.
- RESP:
  - Pulse `*_rvalid_o` for exactly one cycle toward the recorded source, with the registered rdata/err. The other source's rvalid/err stay 0.
  - Go to IDLE; a new grant is possible in the next cycle, not in the RESP cycle.
- Timeout:
  - An 8-bit counter (width $clog2(TIMEOUT+1)) clears on entering REQ and on entering WAIT_RSP, and increments in REQ and WAIT_RSP.
  - When it reaches TIMEOUT: drop `mem_req_o`, set rdata=0 and err=1, go to RESP.
  - A late `mem_rvalid_i` arriving in IDLE, REQ or RESP is ignored.
- No grants are issued while not in IDLE; requesters keep their req asserted meanwhile.

## Timing
- Reset (asserted anywhere, including mid-transaction): state IDLE, `last_src`=INSTR, all outputs 0, registers 0. An in-flight memory transaction is abandoned; its rvalid is dropped.
- Minimum latency, zero-wait memory:
  - cycle 0: req and gnt
  - cycle 1: `mem_req_o`, with `mem_gnt_i` in the same cycle
  - cycle 2: `mem_rvalid_i`
  - cycle 3: `*_rvalid_o`
  - cycle 4: next grant possible
- Every memory-side output and every `*_rvalid_o`/`*_rdata_o`/`*_err_o` is registered. Only `*_gnt_o` is combinational (from state, reqs and `last_src`).
- `mem_gnt_i` and `mem_rvalid_i` asserted in the same REQ cycle: the gnt is taken, the rvalid is ignored. The memory must deliver rvalid at least one cycle after gnt.
- A request deasserted before its grant is simply not served; no error.

## Structure
- Add to `cpu_pkg`:
  - `arb_state_t` enum (IDLE, REQ, WAIT_RSP, RESP)
  - `arb_src_t` enum (SRC_INSTR, SRC_DATA)
  - `ARB_ERR_RDATA` = 32'h0
- One natural sub-module, `rr_arb2`: combinational 2-way round-robin pick from reqs and `last_src`. Everything else lives in `mem_port_arbiter`.

## Test plan
- Single fetch: instr req addr 0x100; memory grants immediately and returns 0x00000013 one cycle later → `instr_gnt_o` at cycle 0, `instr_rvalid_o`=1 with rdata 0x00000013 at cycle 3, data outputs stay 0.
- Tie: both req from reset → DATA granted first. After DATA's RESP the INSTR gnt comes next, then DATA again with both held; `last_src` alternates.
- Write: data we=1, addr 0x2000, wdata 0xCAFEF00D → `mem_we_o`=1 with matching addr/wdata while `mem_req_o`=1; data rvalid with rdata 0 and err 0.
- Wait states: memory withholds gnt 3 cycles and rvalid 5 cycles → `mem_req_o` high for exactly 4 cycles; a single rvalid pulse; no second grant before RESP.
- Timeout: TIMEOUT=4, memory never grants → `mem_req_o` drops after 4 REQ cycles; `instr_rvalid_o`=1, `instr_err_o`=1, rdata 0. A later spurious `mem_rvalid_i` in IDLE produces no output.
- Reset in WAIT_RSP: pull `reset_ni` low → all outputs 0 immediately. After release, a new request is served normally and the stale memory rvalid is ignored.
